xnor16_gate: RTL and testbench

- Registered 16-bit bitwise XNOR unit for the ALU logic-operation group.
- Computes Y = ~(A ^ B) per bit, with zero and all-ones status flags.
- Uses a one-deep valid/ready output stage so it drops into the ALU result pipeline without combinational paths from ready to data.

---
 rtl/alu_pkg.sv | 13 +
 rtl/xnor16_gate_if.sv | 42 ++++
 rtl/xnor16_core.sv | 44 ++++
 rtl/xnor16_gate.sv | 77 +++++++
 tb/tb_xnor16_gate.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, word type and popcount width helper.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;

    // Bits needed to hold a count from 0 to width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/xnor16_gate_if.sv
// Valid/ready operand and result bundle for xnor16_gate.
// XNOR16_MATCH_COUNT_EN adds the match_cnt result field.
interface xnor16_gate_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             all_ones;
    logic             zero;
`ifdef XNOR16_MATCH_COUNT_EN
    logic [cnt_width(WIDTH)-1:0] match_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, all_ones, zero, match_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, all_ones, zero, match_cnt
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, all_ones, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, all_ones, zero
    );
`endif

endinterface

// File: rtl/xnor16_core.sv
// Combinational XNOR datapath with status flags.
// XNOR16_MATCH_COUNT_EN adds an adder-tree popcount of the result.
module xnor16_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    output logic [WIDTH-1:0]            y_next,
    output logic                        all_ones_next,
`ifdef XNOR16_MATCH_COUNT_EN
    output logic [cnt_width(WIDTH)-1:0] match_cnt_next,
`endif
    output logic                        zero_next
);

    assign y_next        = ~(a ^ b);
    assign all_ones_next = &y_next;
    assign zero_next     = ~|y_next;

`ifdef XNOR16_MATCH_COUNT_EN
    localparam int unsigned CW     = cnt_width(WIDTH);
    localparam int unsigned LEAVES = 1 << $clog2(WIDTH);

    // Heap-ordered tree: node n sums nodes 2n and 2n+1, leaves padded to a power of two.
    logic [2*LEAVES-1:1][CW-1:0] tree;

    always_comb begin
        tree = '0;
        for (int unsigned i = 0; i < LEAVES; i++) begin
            if (i < WIDTH) begin
                tree[LEAVES + i] = CW'(y_next[i]);
            end
        end
        for (int unsigned n = LEAVES - 1; n >= 1; n--) begin
            tree[n] = tree[2*n] + tree[2*n + 1];
        end
    end

    assign match_cnt_next = tree[1];
`endif

endmodule

// File: rtl/xnor16_gate.sv
// Registered XNOR unit: one-deep valid/ready output stage around xnor16_core.
// XNOR16_MATCH_COUNT_EN adds a registered match_cnt result.
module xnor16_gate
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    xnor16_gate_if.slave  bus
);

    logic [WIDTH-1:0] y_next;
    logic             all_ones_next;
    logic             zero_next;

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             all_ones_q;
    logic             zero_q;
    logic             in_ready;
    logic             in_xfer;

`ifdef XNOR16_MATCH_COUNT_EN
    logic [cnt_width(WIDTH)-1:0] match_cnt_next;
    logic [cnt_width(WIDTH)-1:0] match_cnt_q;
`endif

    xnor16_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a              (bus.a),
        .b              (bus.b),
        .y_next         (y_next),
        .all_ones_next  (all_ones_next),
`ifdef XNOR16_MATCH_COUNT_EN
        .match_cnt_next (match_cnt_next),
`endif
        .zero_next      (zero_next)
    );

    // Ready depends only on the stage register and downstream ready, never on in_valid.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign in_xfer  = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            all_ones_q  <= 1'b0;
            zero_q      <= 1'b0;
`ifdef XNOR16_MATCH_COUNT_EN
            match_cnt_q <= '0;
`endif
        end else if (in_xfer) begin
            out_valid_q <= 1'b1;
            y_q         <= y_next;
            all_ones_q  <= all_ones_next;
            zero_q      <= zero_next;
`ifdef XNOR16_MATCH_COUNT_EN
            match_cnt_q <= match_cnt_next;
`endif
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.all_ones  = all_ones_q;
    assign bus.zero      = zero_q;
`ifdef XNOR16_MATCH_COUNT_EN
    assign bus.match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_xnor16_gate.sv
// Self-checking bench for xnor16_gate: vector table plus scoreboard-checked sequences.
module tb_xnor16_gate;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        ao;
        logic        z;
        logic [4:0]  cnt;
    } vec_t;

    typedef struct {
        logic [15:0] y;
        logic        ao;
        logic        z;
        logic [4:0]  cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[$];

    xnor16_gate_if #(.WIDTH(16)) bus ();

    xnor16_gate #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.y   = ~(a ^ b);
        e.ao  = (e.y == 16'hFFFF);
        e.z   = (e.y == 16'h0000);
        e.cnt = 5'($countones(e.y));
        return e;
    endfunction

    // Scoreboard monitor, sampling between active edges.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_y", bus.y, 0);
            check("rst_flags", {bus.all_ones, bus.zero}, 0);
`ifdef XNOR16_MATCH_COUNT_EN
            check("rst_match_cnt", bus.match_cnt, 0);
`endif
            q.delete();
        end else begin
            check("out_valid", bus.out_valid, q.size() != 0);
            check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("sb_y", bus.y, e.y);
                check("sb_all_ones", bus.all_ones, e.ao);
                check("sb_zero", bus.zero, e.z);
`ifdef XNOR16_MATCH_COUNT_EN
                check("sb_match_cnt", bus.match_cnt, e.cnt);
`endif
            end
            if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 5'd16};
        tbl[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 5'd16};
        tbl[2] = '{16'hF0F0, 16'hF0F0, 16'hFFFF, 1'b1, 1'b0, 5'd16};
        tbl[3] = '{16'h3333, 16'h3333, 16'hFFFF, 1'b1, 1'b0, 5'd16};
        tbl[4] = '{16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 5'd0};
        tbl[5] = '{16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b1, 5'd0};
        tbl[6] = '{16'h3C3C, 16'hC3C3, 16'h0000, 1'b0, 1'b1, 5'd0};
        tbl[7] = '{16'h1234, 16'h4321, 16'hAEEA, 1'b0, 1'b0, 5'd10};

        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'h1234;
        bus.b         = 16'h4321;
        bus.out_ready = 1'b1;

        // Reset held with in_valid asserted: nothing may load.
        repeat (3) step();
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_y", bus.y, 0);
        rst_n = 1'b1;
        step();
        check("first_y", bus.y, 16'hAEEA);
        check("first_valid", bus.out_valid, 1);

        for (int i = 0; i < 8; i++) begin
            bus.a = tbl[i].a;
            bus.b = tbl[i].b;
            bus.in_valid = 1'b1;
            step();
            check($sformatf("vec%0d_y", i), bus.y, tbl[i].y);
            check($sformatf("vec%0d_all_ones", i), bus.all_ones, tbl[i].ao);
            check($sformatf("vec%0d_zero", i), bus.zero, tbl[i].z);
`ifdef XNOR16_MATCH_COUNT_EN
            check($sformatf("vec%0d_match_cnt", i), bus.match_cnt, tbl[i].cnt);
`endif
        end
        bus.in_valid = 1'b0;
        step();

        // Backpressure: result must hold while new operands wait.
        bus.out_ready = 1'b0;
        bus.a = 16'h1234;
        bus.b = 16'h4321;
        bus.in_valid = 1'b1;
        step();
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_y_hold", bus.y, 16'hAEEA);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", bus.in_ready, 1);
        step();
        check("bp_next_y", bus.y, 16'h0000);
        check("bp_next_zero", bus.zero, 1);
        bus.in_valid = 1'b0;
        step();

        // Streaming: one result per cycle, order checked by the scoreboard.
        for (int i = 0; i < 8; i++) begin
            bus.a = 16'($urandom);
            bus.b = (i == 3) ? ~bus.a : 16'($urandom);
            bus.in_valid = 1'b1;
            step();
            check("stream_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_idle", bus.out_valid, 0);

        // Reset while a result is pending: it must never be delivered.
        bus.out_ready = 1'b0;
        bus.a = 16'hF0F0;
        bus.b = 16'h0F0F;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("pend_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_y", bus.y, 0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        check("drain_queue", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
